encoder_dense_mac: RTL and testbench

ENCODER_DENSE_MAC -- requirements
Module: encoder_dense_mac

---
 rtl/encoder_dense_mac.sv | 190 +++++++++++++++++++
 tb/tb_encoder_dense_mac.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_dense_mac.sv
// -----------------------------------------------------------------------------
// encoder_dense_mac
//
// Dense-layer multiply-accumulate engine for the encoder. It consumes a stream
// of (activation, weight) pairs, one pair per accepted cycle. It accumulates
// VEC_LEN signed products on top of a per-vector bias. It then emits one
// 16-bit quantized result: an arithmetic right shift by SHIFT, followed by
// saturation to the signed 16-bit range.
//
// Operation is a three-state controller:
//   IDLE : waiting for the first element; its accept loads bias + product.
//   ACC  : accumulating the remaining elements.
//   OUT  : result presented; held until out_ready, input is blocked.
//
// Parameters
//   VEC_LEN   : products per output vector (1..256)
//   ACC_WIDTH : signed accumulator width (>= 25), wraps modulo 2^ACC_WIDTH
//   SHIFT     : arithmetic right shift applied before quantization
//
// Ports
//   ap_clk    in   clock, rising edge
//   ap_rst    in   asynchronous active-high reset
//   in_data   in   signed 16-bit activation
//   in_weight in   signed 9-bit weight
//   in_valid  in   input element valid
//   in_ready  out  block can accept an element (IDLE/ACC)
//   bias      in   signed ACC_WIDTH bias, sampled with first element
//   out_data  out  signed 16-bit quantized result
//   out_valid out  result valid (OUT state)
//   out_ready in   downstream accepts result
//   out_sat   out  result was clipped; qualified by out_valid
//
// Build option
//   ENCODER_DENSE_MAC_RELU_EN : when defined, negative shifted results are
//   clamped to 0 before saturation (such results report out_sat = 0).
// -----------------------------------------------------------------------------
module encoder_dense_mac #(
   parameter int VEC_LEN   = 16,
   parameter int ACC_WIDTH = 32,
   parameter int SHIFT     = 8
) (
   input  logic                        ap_clk,
   input  logic                        ap_rst,
   input  logic signed [15:0]          in_data,
   input  logic signed [8:0]           in_weight,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [ACC_WIDTH-1:0] bias,
   output logic signed [15:0]          out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_sat
);

   localparam int CNT_W = 9;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);
   localparam logic signed [ACC_WIDTH-1:0] QMAX = ACC_WIDTH'(32767);
   localparam logic signed [ACC_WIDTH-1:0] QMIN = -ACC_WIDTH'(32768);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Quantization helpers
   // ---------------------------------------------------------------------------

   // Arithmetic shift: floor division by 2^SHIFT for negative values.
   function automatic logic signed [ACC_WIDTH-1:0] asr_floor(
      input logic signed [ACC_WIDTH-1:0] a
   );
      return a >>> SHIFT;
   endfunction

`ifdef ENCODER_DENSE_MAC_RELU_EN
   function automatic logic signed [ACC_WIDTH-1:0] relu(
      input logic signed [ACC_WIDTH-1:0] a
   );
      return a[ACC_WIDTH-1] ? '0 : a;
   endfunction
`else
   function automatic logic signed [ACC_WIDTH-1:0] relu(
      input logic signed [ACC_WIDTH-1:0] a
   );
      return a;
   endfunction
`endif

   // Returns {clipped, value[15:0]}.
   function automatic logic [16:0] sat16(
      input logic signed [ACC_WIDTH-1:0] a
   );
      logic [16:0] r;
      if (a > QMAX) begin
         r = {1'b1, 16'h7fff};
      end else if (a < QMIN) begin
         r = {1'b1, 16'h8000};
      end else begin
         r = {1'b0, a[15:0]};
      end
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // Control and datapath state
   // ---------------------------------------------------------------------------
   state_t                        state;
   logic signed [ACC_WIDTH-1:0]   acc_p0;
   logic [CNT_W-1:0]              cnt_p0;
   logic                          rdy_p0;
   logic signed [15:0]            out_data_p1;
   logic                          sat_p1;
   logic                          vld_p1;

   logic                          accept;
   logic signed [24:0]            prod;
   logic signed [ACC_WIDTH-1:0]   acc_base;
   logic signed [ACC_WIDTH-1:0]   acc_nxt;
   logic                          last_elem;
   logic [16:0]                   quant;

   assign accept = in_valid & rdy_p0;

   // ---------------------------------------------------------------------------
   // Stage p0: product, accumulate, quantize the would-be final value
   // ---------------------------------------------------------------------------
   always_comb begin
      prod      = 25'(in_data) * 25'(in_weight);
      // The first element of a vector starts from bias, later ones from acc.
      acc_base  = (state == IDLE) ? bias : acc_p0;
      acc_nxt   = acc_base + ACC_WIDTH'(prod);
      last_elem = (state == IDLE) ? (VEC_LEN == 1) : (cnt_p0 == LAST_CNT);
      quant     = sat16(relu(asr_floor(acc_nxt)));
   end

   // ---------------------------------------------------------------------------
   // Stage p1: controller and registered result
   // ---------------------------------------------------------------------------
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state       <= IDLE;
         acc_p0      <= '0;
         cnt_p0      <= '0;
         rdy_p0      <= 1'b1;
         out_data_p1 <= '0;
         sat_p1      <= 1'b0;
         vld_p1      <= 1'b0;
      end else begin
         case (state)
            IDLE, ACC: begin
               if (accept) begin
                  acc_p0 <= acc_nxt;
                  cnt_p0 <= (state == IDLE) ? CNT_W'(1) : cnt_p0 + CNT_W'(1);
                  if (last_elem) begin
                     state       <= OUT;
                     rdy_p0      <= 1'b0;
                     vld_p1      <= 1'b1;
                     out_data_p1 <= quant[15:0];
                     sat_p1      <= quant[16];
                  end else begin
                     state <= ACC;
                  end
               end
            end
            OUT: begin
               // Input stays blocked on the release edge; the next vector
               // can only start on the following cycle.
               if (out_ready) begin
                  state  <= IDLE;
                  vld_p1 <= 1'b0;
                  rdy_p0 <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               vld_p1 <= 1'b0;
               rdy_p0 <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = rdy_p0;
   assign out_valid = vld_p1;
   assign out_data  = out_data_p1;
   assign out_sat   = sat_p1;

endmodule

// File: tb/tb_encoder_dense_mac.sv
// -----------------------------------------------------------------------------
// tb_encoder_dense_mac
//
// Directed bench for encoder_dense_mac with VEC_LEN=4, ACC_WIDTH=32, SHIFT=8.
// Expected values are hand computed from the arithmetic: sum of products plus
// bias, floor-shifted by 8, then saturated to 16 bits.
// -----------------------------------------------------------------------------
module tb_encoder_dense_mac;

   logic               ap_clk = 1'b0;
   logic               ap_rst;
   logic signed [15:0] in_data;
   logic signed [8:0]  in_weight;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] bias;
   logic signed [15:0] out_data;
   logic               out_valid;
   logic               out_ready;
   logic               out_sat;

   int total = 0;
   int bad   = 0;

`ifdef ENCODER_DENSE_MAC_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   encoder_dense_mac #(
      .VEC_LEN  (4),
      .ACC_WIDTH(32),
      .SHIFT    (8)
   ) dut (
      .ap_clk   (ap_clk),
      .ap_rst   (ap_rst),
      .in_data  (in_data),
      .in_weight(in_weight),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .bias     (bias),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sat  (out_sat)
   );

   always #5 ap_clk = ~ap_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   // Present one element and wait (bounded) until it is accepted.
   task automatic feed(input logic signed [15:0] d, input logic signed [8:0] w,
                       input logic signed [31:0] b);
      int guard;
      guard = 0;
      in_data   = d;
      in_weight = w;
      bias      = b;
      in_valid  = 1'b1;
      while (!in_ready && guard < 20) begin
         tick();
         guard++;
      end
      chk("feed_ready", in_ready, 1);
      tick();
      in_valid  = 1'b0;
      in_data   = 16'sh5a5a;
      in_weight = 9'sh0a5;
      bias      = 32'sh1234567;
   endtask

   // Four elements; bias only on the first, junk bias on the rest.
   task automatic vec4(input logic signed [15:0] d, input logic signed [8:0] w,
                       input logic signed [31:0] b, input int gap);
      for (int i = 0; i < 4; i++) begin
         feed(d, w, (i == 0) ? b : 32'sh0bad_beef);
         if (i < 3) repeat (gap) tick();
      end
   endtask

   // Result must be visible right after the last accepting edge; then drain.
   task automatic expect_result(input string tag, input int exp_d, input int exp_s);
      chk({tag, ".vld"},  out_valid, 1);
      chk({tag, ".data"}, out_data, exp_d);
      chk({tag, ".sat"},  out_sat, exp_s);
      chk({tag, ".rdy"},  in_ready, 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, ".done_vld"}, out_valid, 0);
      chk({tag, ".done_rdy"}, in_ready, 1);
   endtask

   initial begin
      ap_rst    = 1'b1;
      in_data   = '0;
      in_weight = '0;
      in_valid  = 1'b0;
      bias      = '0;
      out_ready = 1'b0;
      repeat (3) tick();
      chk("rst.vld",  out_valid, 0);
      chk("rst.data", out_data, 0);
      chk("rst.sat",  out_sat, 0);
      ap_rst = 1'b0;
      tick();
      chk("rst.rdy",  in_ready, 1);

      // basic: 4 x (256*1) = 1024 >>> 8 = 4
      vec4(16'sd256, 9'sd1, 32'sd0, 0);
      expect_result("basic", 4, 0);

      // saturation: 4*32767*255 = 33422340 >>> 8 = 130556 -> 32767
      vec4(16'sd32767, 9'sd255, 32'sd0, 0);
      expect_result("sat_pos", 32767, 1);
      // 4*(-32768)*255 = -33423360 >>> 8 = -130560 -> -32768 (0 with ReLU)
      vec4(-16'sd32768, 9'sd255, 32'sd0, 0);
      expect_result("sat_neg", RELU ? 0 : -32768, RELU ? 0 : 1);

      // sign: -1024 >>> 8 = -4 ; bias -1 >>> 8 = -1 (floor)
      vec4(-16'sd256, 9'sd1, 32'sd0, 0);
      expect_result("neg", RELU ? 0 : -4, 0);
      vec4(16'sd0, 9'sd0, -32'sd1, 0);
      expect_result("floor", RELU ? 0 : -1, 0);
      // bias 255 + 4 -> 259 >>> 8 = 1
      vec4(16'sd1, 9'sd1, 32'sd255, 0);
      expect_result("bias", 1, 0);

      // saturation boundaries through bias
      vec4(16'sd0, 9'sd0, 32'sd8388352, 0);   // 32767
      expect_result("edge_max", 32767, 0);
      vec4(16'sd0, 9'sd0, 32'sd8388608, 0);   // 32768 -> clip
      expect_result("over_max", 32767, 1);
      vec4(16'sd0, 9'sd0, -32'sd8388608, 0);  // -32768
      expect_result("edge_min", RELU ? 0 : -32768, 0);
      vec4(16'sd0, 9'sd0, -32'sd8388609, 0);  // -32769 -> clip
      expect_result("under_min", RELU ? 0 : -32768, RELU ? 0 : 1);

      // accumulator wraps: 0x7fffffff + 1 = -2^31, >>> 8 = -8388608 -> clip
      vec4(16'sd1, 9'sd0, 32'sh7fffffff, 0);
      chk("wrap.pre", out_valid, 1);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      feed(16'sd1, 9'sd1, 32'sh7fffffff);
      feed(16'sd0, 9'sd0, 32'sd0);
      feed(16'sd0, 9'sd0, 32'sd0);
      feed(16'sd0, 9'sd0, 32'sd0);
      expect_result("wrap", RELU ? 0 : -32768, RELU ? 0 : 1);

      // backpressure: result held 3 cycles while in_valid stays high
      vec4(16'sd256, 9'sd1, 32'sd0, 0);
      in_data = 16'sd256; in_weight = 9'sd1; bias = 32'sd0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp.vld",  out_valid, 1);
         chk("bp.data", out_data, 4);
         chk("bp.rdy",  in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp.release_vld", out_valid, 0);
      chk("bp.release_rdy", in_ready, 1);
      // no accept on the release edge: three more edges must not finish a vector
      tick(); tick(); tick();
      chk("bp.no_early", out_valid, 0);
      tick();
      in_valid = 1'b0;
      expect_result("bp_next", 4, 0);

      // in_valid gaps of 2 cycles
      vec4(16'sd256, 9'sd1, 32'sd0, 2);
      expect_result("gaps", 4, 0);

      // reset mid-vector, then a clean vector of 512*1
      feed(16'sd256, 9'sd1, 32'sd0);
      feed(16'sd256, 9'sd1, 32'sd0);
      ap_rst = 1'b1;
      tick();
      ap_rst = 1'b0;
      tick();
      chk("rst_mid.vld", out_valid, 0);
      chk("rst_mid.rdy", in_ready, 1);
      vec4(16'sd512, 9'sd1, 32'sd0, 0);
      expect_result("after_rst", 8, 0);

      // asynchronous reset while a result is pending
      vec4(16'sd256, 9'sd1, 32'sd0, 0);
      #2;
      ap_rst = 1'b1;
      #1;
      chk("rst_async.vld",  out_valid, 0);
      chk("rst_async.data", out_data, 0);
      chk("rst_async.sat",  out_sat, 0);
      tick();
      ap_rst = 1'b0;
      tick();
      chk("rst_async.rdy", in_ready, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
